// File: rtl/i2c_master_seq.sv
// Byte-level I2C master sequencer: START/WRITE/READ/STOP commands become open-drain
// SCL/SDA pull-low enables with quarter-bit timing and SCL clock stretching.
module i2c_master_seq #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_nack_i,
    output logic       done_o,
    output logic [7:0] rx_data_o,
    output logic       rx_ack_o,
    output logic       err_o,
    output logic       bus_owned_o,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    input  logic       scl_in_i,
    input  logic       sda_in_i
);

    typedef enum logic [2:0] {StIdle, StStart, StWrite, StRead, StStop, StDone} state_e;

    localparam logic [1:0] CmdStart = 2'b00;
    localparam logic [1:0] CmdWrite = 2'b01;
    localparam logic [1:0] CmdRead  = 2'b10;
    localparam logic [7:0] QtrLast  = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] quarter_q, quarter_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       nack_q, nack_d;
    logic       err_q, err_d;
    logic       owned_q, owned_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ack_q, rx_ack_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       active, run, tick, data_oe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            owned_q   <= 1'b0;
            rx_data_q <= '0;
            rx_ack_q  <= 1'b1;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            err_q     <= err_d;
            owned_q   <= owned_d;
            rx_data_q <= rx_data_d;
            rx_ack_q  <= rx_ack_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        err_d     = err_q;
        owned_d   = owned_q;
        rx_data_d = rx_data_q;
        rx_ack_d  = rx_ack_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;
        data_oe   = 1'b0;

        // A quarter with SCL released only counts once the bus actually reads high.
        active = state_q inside {StStart, StWrite, StRead, StStop};
        run    = scl_oe_q || scl_in_i;
        tick   = active && run && (qcnt_q == QtrLast);
        if (active && run) qcnt_d = tick ? 8'd0 : qcnt_q + 8'd1;
        if (tick) quarter_d = quarter_q + 2'd1;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    qcnt_d    = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    shift_d   = cmd_data_i;
                    nack_d    = cmd_nack_i;
                    err_d     = 1'b0;
                    if (cmd_i == CmdStart) begin
                        state_d = StStart;
                    end else if (!owned_q) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (cmd_i == CmdWrite) begin
                        state_d = StWrite;
                    end else if (cmd_i == CmdRead) begin
                        state_d = StRead;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StStart, StStop: begin
                if (tick && quarter_q == 2'd3) begin
                    state_d = StDone;
                    owned_d = (state_q == StStart);
                end
            end
            StWrite, StRead: begin
                if (tick && quarter_q == 2'd2) begin
                    if (bit_q == 4'd8) begin
                        if (state_q == StWrite) rx_ack_d = sda_in_i;
                    end else if (state_q == StRead) begin
                        shift_d = {shift_q[6:0], sda_in_i};
                    end
                end
                if (tick && quarter_q == 2'd3) begin
                    if (bit_q == 4'd8) begin
                        state_d = StDone;
                        if (state_q == StRead) rx_data_d = shift_q;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (state_q == StWrite) shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Pin levels are set for the quarter being entered so they change on its first cycle.
        if (bit_d == 4'd8) data_oe = (state_d == StRead) ? ~nack_d : 1'b0;
        else               data_oe = (state_d == StWrite) ? ~shift_d[7] : 1'b0;

        case (state_d)
            StStart: begin
                case (quarter_d)
                    2'd0:    sda_oe_d = 1'b0;
                    2'd1:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                    2'd2:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                    default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                endcase
            end
            StStop: begin
                case (quarter_d)
                    2'd0:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                    2'd1:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                    default: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                endcase
            end
            StWrite, StRead: begin
                scl_oe_d = !(quarter_d == 2'd1 || quarter_d == 2'd2);
                sda_oe_d = data_oe;
            end
            default: ;
        endcase
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StDone) && err_q;
    assign bus_owned_o = owned_q;
    assign rx_data_o   = rx_data_q;
    assign rx_ack_o    = rx_ack_q;
    assign scl_oe_o    = scl_oe_q;
    assign sda_oe_o    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq: open-drain bus with a behavioural slave, a
// transaction-level model checked every cycle, and literal expectations per command.
module tb_i2c_master_seq;

    localparam int D = 5;
    localparam logic [1:0] CStart = 2'b00, CWrite = 2'b01, CRead = 2'b10, CStop = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready, done, rx_ack, err, bus_owned, scl_oe, sda_oe;
    logic [7:0] rx_data;
    logic       scl_in, sda_in;
    logic       slv_scl = 1'b0;
    logic       slv_sda;
    logic [1:0] slv_mode = 2'd0;   // 0 silent, 1 ACK a write, 2 transmit slv_byte
    logic [7:0] slv_byte = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fall_total = 0;
    int fall_base = 0;
    int rise_base = 0;
    logic rise_q[$];

    // Model: committed bus state plus the one command in flight.
    logic       m_owned = 1'b0, m_ack = 1'b1;
    logic [7:0] m_rx = 8'h00;
    int         issue_id = 0, done_id = 0, m_acc = 0, m_done_cyc = 0;
    logic [1:0] p_cmd;
    logic       p_legal, p_nack, p_owned, p_ack, p_err;
    logic [7:0] p_rx;

    int lat, id0, guard;
    logic ok;

    assign scl_in = ~(scl_oe | slv_scl);
    assign sda_in = ~(sda_oe | slv_sda);

    i2c_master_seq #(.CLK_DIV(D)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_i      (cmd),
        .cmd_data_i (cmd_data),
        .cmd_nack_i (cmd_nack),
        .done_o     (done),
        .rx_data_o  (rx_data),
        .rx_ack_o   (rx_ack),
        .err_o      (err),
        .bus_owned_o(bus_owned),
        .scl_oe_o   (scl_oe),
        .sda_oe_o   (sda_oe),
        .scl_in_i   (scl_in),
        .sda_in_i   (sda_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge scl_in) fall_total <= fall_total + 1;
    always @(posedge scl_in) rise_q.push_back(sda_in);

    // Slave changes SDA only after SCL falls; j counts falls since the command was accepted.
    always_comb begin
        int j;
        j = fall_total - fall_base;
        slv_sda = 1'b0;
        if (slv_mode == 2'd1) slv_sda = (j == 8);
        else if (slv_mode == 2'd2 && j >= 0 && j < 8) slv_sda = ~slv_byte[7 - j];
    end

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rise_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = rise_q[base + i];
        return b;
    endfunction

    always @(posedge clk) begin
        #2;
        if (rst) begin
            chk1("rst_scl_oe", scl_oe, 1'b0);
            chk1("rst_sda_oe", sda_oe, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_err", err, 1'b0);
            chk1("rst_bus_owned", bus_owned, 1'b0);
            chk1("rst_cmd_ready", cmd_ready, 1'b1);
            chk1("rst_rx_ack", rx_ack, 1'b1);
            chkv("rst_rx_data", 32'(rx_data), 32'h0);
            m_owned = 1'b0;
            m_ack   = 1'b1;
            m_rx    = 8'h00;
            done_id = issue_id;
        end else if (issue_id != done_id && cyc >= m_acc) begin
            chk1("done_timing", done, cyc == m_done_cyc);
            chk1("busy_ready", cmd_ready, 1'b0);
            if (!p_legal) begin
                chk1("illegal_scl_idle", scl_oe, 1'b0);
                chk1("illegal_sda_idle", sda_oe, 1'b0);
            end
            if (p_legal && p_cmd == CRead && p_nack) chk1("read_nack_sda_oe", sda_oe, 1'b0);
            if (cyc == m_done_cyc) begin
                chk1("done_err", err, p_err);
                chk1("done_bus_owned", bus_owned, p_owned);
                chk1("done_rx_ack", rx_ack, p_ack);
                chkv("done_rx_data", 32'(rx_data), 32'(p_rx));
                m_owned = p_owned;
                m_ack   = p_ack;
                m_rx    = p_rx;
                done_id = issue_id;
            end else begin
                chk1("busy_bus_owned", bus_owned, m_owned);
            end
        end else begin
            chk1("idle_ready", cmd_ready, 1'b1);
            chk1("idle_done", done, 1'b0);
            chk1("idle_bus_owned", bus_owned, m_owned);
            chk1("idle_rx_ack", rx_ack, m_ack);
            chkv("idle_rx_data", 32'(rx_data), 32'(m_rx));
        end
    end

    task automatic issue_start(input logic [1:0] c, input logic [7:0] d, input logic n,
                               input int extra, output logic acc);
        int w;
        int l;
        @(negedge clk);
        cmd = c; cmd_data = d; cmd_nack = n; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            chk1("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            acc = 1'b0;
            return;
        end
        p_cmd   = c;
        p_nack  = n;
        p_legal = (c == CStart) || m_owned;
        p_err   = !p_legal;
        p_owned = !p_legal ? m_owned : (c == CStart) ? 1'b1 : (c == CStop) ? 1'b0 : m_owned;
        p_rx    = (p_legal && c == CRead) ? slv_byte : m_rx;
        p_ack   = (p_legal && c == CWrite) ? (slv_mode != 2'd1) : m_ack;
        l       = !p_legal ? 0 : (c == CStart || c == CStop) ? 4 * D : 36 * D;
        m_acc      = cyc + 1;
        m_done_cyc = m_acc + l + extra;
        fall_base  = fall_total;
        rise_base  = rise_q.size();
        issue_id++;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = 1'b1;
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic n,
                           input int extra, output int l);
        logic acc;
        issue_start(c, d, n, extra, acc);
        l = -1;
        if (!acc) return;
        l = 0;
        while (!done && l < 2000) begin @(negedge clk); l++; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_cmd(CStop, 8'h00, 1'b0, 0, lat);
        chkv("illegal_stop_latency", lat, 0);
        run_cmd(CWrite, 8'h55, 1'b0, 0, lat);
        chkv("illegal_write_latency", lat, 0);
        chk1("illegal_keeps_rx_ack", rx_ack, 1'b1);

        run_cmd(CStart, 8'h00, 1'b0, 0, lat);
        chkv("start_latency", lat, 20);
        chk1("start_owned", bus_owned, 1'b1);

        slv_mode = 2'd1;
        run_cmd(CWrite, 8'h3C, 1'b0, 0, lat);
        slv_mode = 2'd0;
        chkv("write3c_latency", lat, 180);
        chkv("write3c_rises", rise_q.size() - rise_base, 9);
        chkv("write3c_sda_bits", 32'(rise_byte(rise_base)), 32'h3C);
        chk1("write3c_ack_level", rise_q[rise_base + 8], 1'b0);
        chk1("write3c_rx_ack", rx_ack, 1'b0);

        run_cmd(CWrite, 8'hFF, 1'b0, 0, lat);
        chkv("writeff_latency", lat, 180);
        chk1("writeff_rx_ack", rx_ack, 1'b1);

        slv_mode = 2'd2; slv_byte = 8'hA5;
        run_cmd(CRead, 8'h00, 1'b1, 0, lat);
        slv_mode = 2'd0;
        chkv("reada5_latency", lat, 180);
        chkv("reada5_rx_data", 32'(rx_data), 32'hA5);
        chk1("reada5_nack_level", rise_q[rise_base + 8], 1'b1);

        slv_mode = 2'd2; slv_byte = 8'h5A;
        run_cmd(CRead, 8'h00, 1'b0, 0, lat);
        slv_mode = 2'd0;
        chkv("read5a_rx_data", 32'(rx_data), 32'h5A);
        chk1("read5a_ack_level", rise_q[rise_base + 8], 1'b0);

        // Bit 3 is the fifth bit sent; its q1 starts 85 cycles after accept.
        slv_mode = 2'd1;
        id0 = issue_id;
        guard = 0;
        fork
            run_cmd(CWrite, 8'h96, 1'b0, 37, lat);
            begin
                while (issue_id == id0 && guard < 100) begin @(negedge clk); guard++; end
                while (cyc < m_acc + 82) @(negedge clk);
                slv_scl = 1'b1;
                while (cyc < m_acc + 122) @(negedge clk);
                slv_scl = 1'b0;
            end
        join
        slv_mode = 2'd0;
        chkv("stretch_latency", lat, 217);
        chk1("stretch_rx_ack", rx_ack, 1'b0);

        run_cmd(CStart, 8'h00, 1'b0, 0, lat);
        chkv("restart_latency", lat, 20);
        run_cmd(CStop, 8'h00, 1'b0, 0, lat);
        chkv("stop_latency", lat, 20);
        chk1("stop_owned", bus_owned, 1'b0);
        chk1("stop_scl_released", scl_oe, 1'b0);
        chk1("stop_sda_released", sda_oe, 1'b0);

        run_cmd(CStart, 8'h00, 1'b0, 0, lat);
        issue_start(CWrite, 8'h00, 1'b0, 0, ok);
        if (ok) begin
            while (cyc < m_acc + 42) @(negedge clk);
            chk1("bit5_scl_low", scl_oe, 1'b1);
            chk1("bit5_sda_low", sda_oe, 1'b1);
            rst = 1'b1;
            #1;
            chk1("async_rst_scl", scl_oe, 1'b0);
            chk1("async_rst_sda", sda_oe, 1'b0);
            chk1("async_rst_owned", bus_owned, 1'b0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk1("post_rst_ready", cmd_ready, 1'b1);
        end
        run_cmd(CStart, 8'h00, 1'b0, 0, lat);
        chkv("post_rst_start_latency", lat, 20);
        chk1("post_rst_owned", bus_owned, 1'b1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
